// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: condition codes, FSM states and
// flag bit positions within the {N,V,Z} status word.
package branch_pkg;

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    // True for condition codes with no defined meaning (never taken).
    function automatic logic cond_reserved(input logic [2:0] cond);
        return cond > COND_BLE;
    endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Controller-facing port bundle of the branch unit: ALU flag load, PC
// stepping, branch request/completion and the PC/flags outputs.
interface branch_unit_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned OFF_W = 8
);
    logic             flag_ld;
    logic [2:0]       z_in;
    logic             pc_inc;
    logic             br_req;
    logic [2:0]       br_cond;
    logic [OFF_W-1:0] br_off;
    logic             br_busy;
    logic             br_done;
    logic             br_taken;
    logic [PC_W-1:0]  pc;
    logic [2:0]       flags;

    modport master (
        output flag_ld, z_in, pc_inc, br_req, br_cond, br_off,
        input  br_busy, br_done, br_taken, pc, flags
    );

    modport slave (
        input  flag_ld, z_in, pc_inc, br_req, br_cond, br_off,
        output br_busy, br_done, br_taken, pc, flags
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over an {N,V,Z} flag word;
// reserved codes evaluate as not taken.
module cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic n, v, z, lt;

    always_comb begin
        n     = flags[FLAG_N];
        v     = flags[FLAG_V];
        z     = flags[FLAG_Z];
        lt    = n ^ v;
        taken = 1'b0;
        if (!cond_reserved(cond)) begin
            case (cond)
                COND_B:   taken = 1'b1;
                COND_BEQ: taken = z;
                COND_BNE: taken = ~z;
                COND_BLT: taken = lt;
                COND_BLE: taken = lt | z;
                default:  taken = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/branch_unit.sv
// PC and conditional-branch sequencer: owns the PC and ALU flags register and
// runs each branch through IDLE -> EVAL -> DONE using a captured snapshot.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned PC_W     = 9,
    parameter int unsigned OFF_W    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic      clk,
    input  logic      reset_n,
    branch_unit_if.slave bus
);
    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [2:0]       flags_q;
    logic             busy_q;
    logic             done_q;
    logic             taken_q;

    logic [2:0]       snap_cond_q;
    logic [OFF_W-1:0] snap_off_q;
    logic [PC_W-1:0]  snap_base_q;
    logic [2:0]       snap_flags_q;

    logic [2:0]       eff_flags;
    logic             cond_taken;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  target_pc;

    // A flag load on the capture edge is forwarded straight into the snapshot.
    assign eff_flags = bus.flag_ld ? bus.z_in : flags_q;

    assign off_ext   = PC_W'($signed(snap_off_q));
    assign seq_pc    = snap_base_q + PC_W'(1);
    assign target_pc = seq_pc + off_ext;

    cond_eval u_cond_eval (
        .cond  (snap_cond_q),
        .flags (snap_flags_q),
        .taken (cond_taken)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 3'b000;
        end else if (bus.flag_ld) begin
            flags_q <= bus.z_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= PC_W'(RESET_PC);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            taken_q      <= 1'b0;
            snap_cond_q  <= 3'b000;
            snap_off_q   <= '0;
            snap_base_q  <= '0;
            snap_flags_q <= 3'b000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.br_req) begin
                        snap_cond_q  <= bus.br_cond;
                        snap_off_q   <= bus.br_off;
                        snap_base_q  <= pc_q;
                        snap_flags_q <= eff_flags;
                        busy_q       <= 1'b1;
                        state_q      <= ST_EVAL;
                    end else if (bus.pc_inc) begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                ST_EVAL: begin
                    pc_q    <= cond_taken ? target_pc : seq_pc;
                    taken_q <= cond_taken;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.br_busy  = busy_q;
    assign bus.br_done  = done_q;
    assign bus.br_taken = taken_q;
    assign bus.pc       = pc_q;
    assign bus.flags    = flags_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: reset, each condition class, PC wrap,
// forwarding, busy lockout and reset abort, against hand-computed values.
module tb_branch_unit;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    branch_unit_if #(.PC_W(9), .OFF_W(8)) bus ();

    branch_unit #(.PC_W(9), .OFF_W(8), .RESET_PC(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flag_ld = 1'b0;
        bus.z_in    = 3'b000;
        bus.pc_inc  = 1'b0;
        bus.br_req  = 1'b0;
        bus.br_cond = 3'b000;
        bus.br_off  = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_flags(input logic [2:0] z);
        bus.flag_ld = 1'b1;
        bus.z_in    = z;
        tick();
        bus.flag_ld = 1'b0;
    endtask

    task automatic step_pc(input int n);
        bus.pc_inc = 1'b1;
        repeat (n) tick();
        bus.pc_inc = 1'b0;
    endtask

    task automatic branch(input string tag, input logic [2:0] cond, input logic [7:0] off,
                          input logic [8:0] exp_pc, input logic exp_taken);
        logic [8:0] base;
        base        = bus.pc;
        bus.br_req  = 1'b1;
        bus.br_cond = cond;
        bus.br_off  = off;
        tick();
        bus.br_req  = 1'b0;
        check({tag, " busy E0"}, 32'(bus.br_busy), 32'd1);
        check({tag, " pc E0"}, 32'(bus.pc), 32'(base));
        tick();
        check({tag, " pc E1"}, 32'(bus.pc), 32'(exp_pc));
        check({tag, " done E1"}, 32'(bus.br_done), 32'd1);
        check({tag, " taken"}, 32'(bus.br_taken), 32'(exp_taken));
        tick();
        check({tag, " done E2"}, 32'(bus.br_done), 32'd0);
        check({tag, " busy E2"}, 32'(bus.br_busy), 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();
        check("rst pc", 32'(bus.pc), 32'd0);
        check("rst flags", 32'(bus.flags), 32'd0);
        check("rst busy", 32'(bus.br_busy), 32'd0);
        check("rst done", 32'(bus.br_done), 32'd0);
        check("rst taken", 32'(bus.br_taken), 32'd0);

        step_pc(3);
        check("inc pc", 32'(bus.pc), 32'd3);

        load_flags(3'b001);
        check("flags ld", 32'(bus.flags), 32'd1);
        branch("beq", 3'b001, 8'd5, 9'd9, 1'b1);
        branch("bne", 3'b010, 8'd5, 9'd10, 1'b0);
        branch("rsv", 3'b111, 8'd5, 9'd11, 1'b0);
        branch("ble z", 3'b100, 8'd2, 9'd14, 1'b1);

        // BLT backwards across zero, then forward wrap by pc_inc.
        do_reset();
        load_flags(3'b100);
        branch("blt wrap", 3'b011, 8'hFE, 9'd511, 1'b1);
        step_pc(1);
        check("inc wrap", 32'(bus.pc), 32'd0);
        load_flags(3'b110);
        branch("blt nv", 3'b011, 8'd3, 9'd1, 1'b0);

        // Forwarded flag load, branch and pc_inc all on one edge.
        do_reset();
        step_pc(4);
        check("pc four", 32'(bus.pc), 32'd4);
        bus.flag_ld = 1'b1;
        bus.z_in    = 3'b001;
        bus.pc_inc  = 1'b1;
        bus.br_req  = 1'b1;
        bus.br_cond = 3'b001;
        bus.br_off  = 8'd2;
        tick();
        idle_inputs();
        check("fwd pc E0", 32'(bus.pc), 32'd4);
        check("fwd flags", 32'(bus.flags), 32'd1);
        tick();
        check("fwd pc", 32'(bus.pc), 32'd7);
        check("fwd taken", 32'(bus.br_taken), 32'd1);
        tick();

        // Flag load during EVAL must not alter the captured Z=1 (BNE not taken).
        bus.br_req  = 1'b1;
        bus.br_cond = 3'b010;
        bus.br_off  = 8'd3;
        tick();
        idle_inputs();
        bus.flag_ld = 1'b1;
        tick();
        bus.flag_ld = 1'b0;
        check("late ld pc", 32'(bus.pc), 32'd8);
        check("late ld taken", 32'(bus.br_taken), 32'd0);
        check("late ld flags", 32'(bus.flags), 32'd0);
        tick();

        // Request and pc_inc held high through a whole branch.
        bus.br_req  = 1'b1;
        bus.pc_inc  = 1'b1;
        bus.br_cond = 3'b000;
        bus.br_off  = 8'd1;
        tick();
        check("hold pc E0", 32'(bus.pc), 32'd8);
        tick();
        check("hold pc E1", 32'(bus.pc), 32'd10);
        tick();
        idle_inputs();
        check("hold pc E2", 32'(bus.pc), 32'd10);
        check("hold busy E2", 32'(bus.br_busy), 32'd0);
        tick();
        check("hold pc E3", 32'(bus.pc), 32'd10);
        check("hold done E3", 32'(bus.br_done), 32'd0);

        // Reset pulsed while the branch sits in EVAL.
        bus.br_req  = 1'b1;
        bus.br_cond = 3'b000;
        bus.br_off  = 8'd5;
        tick();
        idle_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check("abort pc", 32'(bus.pc), 32'd0);
        check("abort busy", 32'(bus.br_busy), 32'd0);
        @(posedge clk);
        #1;
        check("abort done0", 32'(bus.br_done), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("abort done1", 32'(bus.br_done), 32'd0);
        check("abort pc2", 32'(bus.pc), 32'd0);
        check("abort taken", 32'(bus.br_taken), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
